// File: rtl/sqgen_pkg.sv
// ----------------------------------------------------------------------------
// sqgen_pkg
// Shared types and helpers for the square tone generator.
//   sample_t  : one 16-bit two's-complement audio sample
//   SAMPLE_W  : width of one channel sample
//   WORD_W    : width of the packed stereo word {left, right}
//   pack_lr   : packs a left/right pair into one stereo word
// ----------------------------------------------------------------------------
package sqgen_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic logic [WORD_W-1:0] pack_lr(input sample_t l, input sample_t r);
    return {l, r};
  endfunction

endpackage

// File: rtl/sqgen_tick_div.sv
// ----------------------------------------------------------------------------
// sqgen_tick_div
// Half-period divider: counts 0..HALF-1 and flags the last count so the
// parent can flip the square-wave phase.
// Ports:
//   CLK   in  1  clock, rising edge
//   RST_N in  1  asynchronous active-low reset (counter returns to 0)
//   tick  out 1  high during the cycle in which the counter equals HALF-1
// ----------------------------------------------------------------------------
module sqgen_tick_div #(
  parameter int HALF = 4
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  // Wide enough to hold HALF, so HALF-1 always fits (HALF=1 still gets 1 bit).
  localparam int CNT_W = $clog2(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_LAST);
  assign tick   = w_last;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/square_tone_generator.sv
// ----------------------------------------------------------------------------
// square_tone_generator
// Free-running square-wave test tone for the audio path. Produces a 32-bit
// stereo word {left, right} that only changes on phase flips, so a consumer
// may latch it at any rate.
// Parameters:
//   CLK_FREQ_HZ  clock frequency in Hz
//   TONE_FREQ_HZ square-wave frequency in Hz
//   AMPLITUDE    positive peak (1..16'h7FFF); low level is -AMPLITUDE
// Ports:
//   CLK   in  1   clock, rising edge
//   RST_N in  1   asynchronous active-low reset
//   data  out 32  registered sample word {left[15:0], right[15:0]}
// Build option:
//   SQGEN_RIGHT_INVERT_EN  when defined, the right channel carries the
//                          opposite polarity of the left channel.
// ----------------------------------------------------------------------------
module square_tone_generator
  import sqgen_pkg::*;
#(
  parameter int          CLK_FREQ_HZ  = 100_000_000,
  parameter int          TONE_FREQ_HZ = 440,
  parameter logic [15:0] AMPLITUDE    = 16'h4000
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic [WORD_W-1:0] data
);

  localparam int HALF = CLK_FREQ_HZ / (2 * TONE_FREQ_HZ);
  // Keeps the divider elaborating sanely while the error below is reported.
  localparam int HALF_DIV = (HALF < 1) ? 1 : HALF;

  localparam sample_t POS_LVL = sample_t'(AMPLITUDE);
  localparam sample_t NEG_LVL = -POS_LVL;

  if (HALF < 1) begin : g_bad_half
    $error("square_tone_generator: HALF must be >= 1 (got %0d)", HALF);
  end
  if ((AMPLITUDE == 16'h0000) || (AMPLITUDE > 16'h7FFF)) begin : g_bad_amp
    $error("square_tone_generator: AMPLITUDE must be in 1..16'h7FFF");
  end

  logic              w_tick;
  logic              w_phase_next;
  sample_t           w_left;
  sample_t           w_right;
  logic              r_phase;
  logic [WORD_W-1:0] r_data;

  sqgen_tick_div #(
    .HALF (HALF_DIV)
  ) u_tick_div (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (w_tick)
  );

  // The data register follows the phase being entered this edge, so the
  // output is never a cycle behind the phase flip.
  assign w_phase_next = r_phase ^ w_tick;

  always_comb begin
    w_left = w_phase_next ? POS_LVL : NEG_LVL;
`ifdef SQGEN_RIGHT_INVERT_EN
    w_right = w_phase_next ? NEG_LVL : POS_LVL;
`else
    w_right = w_left;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_phase <= 1'b0;
      r_data  <= '0;
    end else begin
      r_phase <= w_phase_next;
      r_data  <= pack_lr(w_left, w_right);
    end
  end

  assign data = r_data;

endmodule

// File: tb/tb_square_tone_generator.sv
// ----------------------------------------------------------------------------
// tb_square_tone_generator
// Directed bench for square_tone_generator. Main instance: CLK 16 Hz,
// tone 2 Hz (HALF=4), A=16'h4000. Second instance: CLK 2 Hz, tone 1 Hz
// (HALF=1). Honours SQGEN_RIGHT_INVERT_EN for the expected words.
// ----------------------------------------------------------------------------
module tb_square_tone_generator;

`ifdef SQGEN_RIGHT_INVERT_EN
  localparam logic [31:0] LO = 32'hC000_4000;
  localparam logic [31:0] HI = 32'h4000_C000;
`else
  localparam logic [31:0] LO = 32'hC000_C000;
  localparam logic [31:0] HI = 32'h4000_4000;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [31:0] data1;

  int n_cmp = 0;
  int n_mis = 0;

  square_tone_generator #(
    .CLK_FREQ_HZ  (16),
    .TONE_FREQ_HZ (2),
    .AMPLITUDE    (16'h4000)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .data  (data)
  );

  square_tone_generator #(
    .CLK_FREQ_HZ  (2),
    .TONE_FREQ_HZ (1),
    .AMPLITUDE    (16'h4000)
  ) dut_h1 (
    .CLK   (clk),
    .RST_N (rst_n),
    .data  (data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Edge k after reset release: phase = floor(k/4) mod 2.
  function automatic logic [31:0] exp_word(input int k);
    return (((k / 4) % 2) == 1) ? HI : LO;
  endfunction

  logic [31:0] dir_tbl [1:8];
  logic [31:0] prev;
  int          run_len;
  int          n_hi;
  int          n_lo;

  initial begin
    dir_tbl[1] = LO; dir_tbl[2] = LO; dir_tbl[3] = LO;
    dir_tbl[4] = HI; dir_tbl[5] = HI; dir_tbl[6] = HI; dir_tbl[7] = HI;
    dir_tbl[8] = LO;

    // Reset held for 5 edges.
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("reset_hold[%0d]", i), data, 32'h0);
      check($sformatf("reset_hold_h1[%0d]", i), data1, 32'h0);
    end

    // Release between edges, then directed edges 1..8.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("edge%0d", k), data, dir_tbl[k]);
    end

    // 100 periods: per-cycle model check, run lengths, duty.
    prev    = data;
    run_len = 1;
    n_hi    = 0;
    n_lo    = 0;
    for (int k = 9; k <= 808; k++) begin
      step();
      if (data !== exp_word(k)) check($sformatf("model_k%0d", k), data, exp_word(k));
      else n_cmp++;
      if (data === prev) begin
        run_len++;
      end else begin
        check($sformatf("run_len_k%0d", k), 32'(run_len), 32'd4);
        run_len = 1;
      end
      prev = data;
      if (data === HI) n_hi++;
      else if (data === LO) n_lo++;
    end
    check("hi_count", 32'(n_hi), 32'd400);
    check("lo_count", 32'(n_lo), 32'd400);

    // Move to k=814 (third cycle of a high level), then async reset.
    for (int k = 809; k <= 814; k++) step();
    check("pre_reset_high", data, HI);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_clear", data, 32'h0);
    check("async_clear_h1", data1, 32'h0);
    step();
    check("reset_hold_mid", data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("restart_edge%0d", k), data, dir_tbl[k]);
    end

    // HALF=1 instance: alternates every cycle between the two levels.
    prev = data1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("h1_toggle[%0d]", i), data1, (prev === HI) ? LO : HI);
      prev = data1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
